// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [0:0] {
    FETCH_PRI = 1'b0,
    LDR_FORCE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 8;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive denied loader cycles; hit flags the
// denied cycle on which the count reaches STARVE_MAX-1.
module imem_arb_starve_cnt
  import imem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W:0]   HIT_AT = (CNT_W + 1)'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] SAT    = CNT_W'(STARVE_MAX);

  logic [CNT_W:0] cnt_next;

  always_comb begin
    cnt_next = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    hit      = inc && !clr && (cnt_next >= HIT_AT);
  end

  // Clear wins over increment; the count sticks at SAT rather than wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Fixed-priority fetch/loader arbiter for the single-port instruction BRAM.
// Optional perf counters are built when IMEM_ARB_PERF_EN is defined.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_ld_cnt,
  output logic [31:0]       perf_force_cnt
`endif
);

  state_t            state;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              cnt_hit;

  // Handshake: a requester raises req with addr/data stable and holds them
  // until it sees gnt high in the same cycle; gnt is combinational, at most
  // one gnt per cycle, and a read's rvalid follows exactly one cycle later.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rstn) begin
      if (ld_req && ((state == LDR_FORCE) || !if_req)) begin
        ld_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | ld_gnt;
    mem_we    = ld_gnt & ld_we;
    mem_addr  = ld_gnt ? ld_addr : (if_gnt ? if_addr : addr_q);
    mem_wdata = mem_we ? ld_wdata : '0;
    cnt_inc   = ld_req && !ld_gnt;
    cnt_clr   = ld_gnt || !ld_req;
  end

  imem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (dbg_starve_cnt),
    .hit  (cnt_hit)
  );

  // A forced slot is single-shot: LDR_FORCE always falls back to FETCH_PRI.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FETCH_PRI;
    end else begin
      case (state)
        FETCH_PRI: if (cnt_hit) state <= LDR_FORCE;
        LDR_FORCE: state <= FETCH_PRI;
        default:   state <= FETCH_PRI;
      endcase
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
    end else begin
      if (if_gnt) begin
        owner_q <= OWN_IF;
      end else if (ld_gnt && !ld_we) begin
        owner_q <= OWN_LD;
      end else begin
        owner_q <= OWN_NONE;
      end
      if (mem_en) begin
        addr_q <= mem_addr;
      end
    end
  end

  // Owner sees BRAM data directly; the other side keeps its last read word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      if (owner_q == OWN_IF) if_rdata_q <= mem_rdata;
      if (owner_q == OWN_LD) ld_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    ld_rvalid = (owner_q == OWN_LD);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    ld_rdata  = ld_rvalid ? mem_rdata : ld_rdata_q;
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_if_cnt    <= '0;
      perf_ld_cnt    <= '0;
      perf_force_cnt <= '0;
    end else begin
      if (if_gnt) perf_if_cnt <= perf_if_cnt + 32'd1;
      if (ld_gnt) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (ld_gnt && (state == LDR_FORCE)) perf_force_cnt <= perf_force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural one-cycle BRAM model.
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rstn;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  state_t            dbg_state;
  logic [7:0]        dbg_starve_cnt;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]       perf_if_cnt;
  logic [31:0]       perf_ld_cnt;
  logic [31:0]       perf_force_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  imem_arbiter dut (
    .clk            (clk),
    .rstn           (rstn),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .ld_req         (ld_req),
    .ld_we          (ld_we),
    .ld_addr        (ld_addr),
    .ld_wdata       (ld_wdata),
    .ld_gnt         (ld_gnt),
    .ld_rvalid      (ld_rvalid),
    .ld_rdata       (ld_rdata),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_if_cnt    (perf_if_cnt),
    .perf_ld_cnt    (perf_ld_cnt),
    .perf_force_cnt (perf_force_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // BRAM model: one-cycle read latency, synchronous write
  logic [DATA_W-1:0] bram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    if_req   = 1'b0;
    if_addr  = '0;
    ld_req   = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;
  endtask

  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) bram[i] = '0;
    bram[10'h010] = 32'hDEAD_BEEF;
    bram[10'h030] = 32'hA5A5_0030;
    bram[10'h040] = 32'h4040_4040;
    bram[10'h001] = 32'h1111_1111;
    bram[10'h002] = 32'h2222_2222;
    bram[10'h003] = 32'h3333_3333;

    // reset with requests pending: nothing may be granted
    rstn = 1'b0;
    drive_idle();
    if_req   = 1'b1;
    if_addr  = 10'h055;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 10'h066;
    ld_wdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_if_gnt",    32'(if_gnt), 32'd0);
    chk("rst_ld_gnt",    32'(ld_gnt), 32'd0);
    chk("rst_mem_en",    32'(mem_en), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata",  if_rdata, 32'd0);
    chk("rst_ld_rdata",  ld_rdata, 32'd0);
    chk("rst_state",     32'(dbg_state), 32'(FETCH_PRI));
    chk("rst_cnt",       32'(dbg_starve_cnt), 32'd0);
    drive_idle();
    tick();
    tick();
    rstn = 1'b1;

    // single fetch read
    if_req  = 1'b1;
    if_addr = 10'h010;
    settle();
    chk("t1_if_gnt",   32'(if_gnt), 32'd1);
    chk("t1_ld_gnt",   32'(ld_gnt), 32'd0);
    chk("t1_mem_en",   32'(mem_en), 32'd1);
    chk("t1_mem_we",   32'(mem_we), 32'd0);
    chk("t1_mem_addr", 32'(mem_addr), 32'h010);
    tick();
    if_req = 1'b0;
    chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata",  if_rdata, 32'hDEAD_BEEF);
    chk("t1_ld_rvalid", 32'(ld_rvalid), 32'd0);
    settle();
    chk("t1_idle_en",   32'(mem_en), 32'd0);
    chk("t1_idle_addr", 32'(mem_addr), 32'h010);

    // loader write then fetch read of the same word
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 10'h020;
    ld_wdata = 32'h1234_5678;
    settle();
    chk("t2_ld_gnt",    32'(ld_gnt), 32'd1);
    chk("t2_mem_we",    32'(mem_we), 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t2_mem_addr",  32'(mem_addr), 32'h020);
    tick();
    drive_idle();
    chk("t2_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("t2_if_rvalid", 32'(if_rvalid), 32'd0);
    if_req  = 1'b1;
    if_addr = 10'h020;
    settle();
    chk("t2_mem_we_off", 32'(mem_we), 32'd0);
    chk("t2_if_gnt",     32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    chk("t2_if_rvalid2", 32'(if_rvalid), 32'd1);
    chk("t2_if_rdata",   if_rdata, 32'h1234_5678);

    // starvation: both held, 7 fetch grants then a forced loader grant
    if_req  = 1'b1;
    if_addr = 10'h040;
    ld_req  = 1'b1;
    ld_we   = 1'b0;
    ld_addr = 10'h030;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("t3_if_gnt", 32'(if_gnt), 32'd1);
      chk("t3_ld_gnt", 32'(ld_gnt), 32'd0);
      chk("t3_cnt",    32'(dbg_starve_cnt), 32'(i));
      tick();
    end
    settle();
    chk("t3_force_state", 32'(dbg_state), 32'(LDR_FORCE));
    chk("t3_force_ld",    32'(ld_gnt), 32'd1);
    chk("t3_force_if",    32'(if_gnt), 32'd0);
    chk("t3_force_addr",  32'(mem_addr), 32'h030);
    tick();
    ld_req = 1'b0;
    chk("t3_ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("t3_ld_rdata",  ld_rdata, 32'hA5A5_0030);
    chk("t3_if_quiet",  32'(if_rvalid), 32'd0);
    settle();
    chk("t3_resume_if",    32'(if_gnt), 32'd1);
    chk("t3_resume_state", 32'(dbg_state), 32'(FETCH_PRI));
    chk("t3_resume_cnt",   32'(dbg_starve_cnt), 32'd0);
    tick();
    if_req = 1'b0;
    chk("t3_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t3_if_rdata",  if_rdata, 32'h4040_4040);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_if",    perf_if_cnt, 32'd10);
    chk("perf_ld",    perf_ld_cnt, 32'd2);
    chk("perf_force", perf_force_cnt, 32'd1);
`endif

    // dropping ld_req clears the count
    if_req = 1'b1;
    ld_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t3b_cnt3", 32'(dbg_starve_cnt), 32'd3);
    ld_req = 1'b0;
    tick();
    chk("t3b_cnt0", 32'(dbg_starve_cnt), 32'd0);
    drive_idle();
    tick();

    // alternating fetch / loader / fetch reads
    if_req  = 1'b1;
    if_addr = 10'h001;
    settle();
    chk("t4_gnt1", 32'(if_gnt), 32'd1);
    tick();
    drive_idle();
    ld_req  = 1'b1;
    ld_addr = 10'h002;
    chk("t4_if_rv1", 32'(if_rvalid), 32'd1);
    chk("t4_if_rd1", if_rdata, 32'h1111_1111);
    chk("t4_ld_rv1", 32'(ld_rvalid), 32'd0);
    settle();
    chk("t4_gnt2", 32'(ld_gnt), 32'd1);
    tick();
    drive_idle();
    if_req  = 1'b1;
    if_addr = 10'h003;
    chk("t4_ld_rv2",   32'(ld_rvalid), 32'd1);
    chk("t4_ld_rd2",   ld_rdata, 32'h2222_2222);
    chk("t4_if_rv2",   32'(if_rvalid), 32'd0);
    chk("t4_if_hold2", if_rdata, 32'h1111_1111);
    settle();
    chk("t4_gnt3", 32'(if_gnt), 32'd1);
    tick();
    drive_idle();
    chk("t4_if_rv3",   32'(if_rvalid), 32'd1);
    chk("t4_if_rd3",   if_rdata, 32'h3333_3333);
    chk("t4_ld_rv3",   32'(ld_rvalid), 32'd0);
    chk("t4_ld_hold3", ld_rdata, 32'h2222_2222);
    tick();

    // reset while a fetch read is in flight
    if_req  = 1'b1;
    if_addr = 10'h001;
    settle();
    chk("t5_gnt", 32'(if_gnt), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_gnt",    32'(if_gnt), 32'd0);
    chk("t5_rst_en",     32'(mem_en), 32'd0);
    chk("t5_rst_addr",   32'(mem_addr), 32'd0);
    chk("t5_rst_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    chk("t5_in_rst_rv", 32'(if_rvalid), 32'd0);
    if_req = 1'b0;
    rstn   = 1'b1;
    tick();
    chk("t5_post_if_rv", 32'(if_rvalid), 32'd0);
    chk("t5_post_ld_rv", 32'(ld_rvalid), 32'd0);
    chk("t5_post_rdata", if_rdata, 32'd0);

    // idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_mem_en", 32'(mem_en), 32'd0);
      chk("t6_if_rv",  32'(if_rvalid), 32'd0);
      chk("t6_ld_rv",  32'(ld_rvalid), 32'd0);
      chk("t6_cnt",    32'(dbg_starve_cnt), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
